wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback datapath for the dynamic-pipeline CPU.
- Latches the instruction leaving MEM and performs load byte/half extraction and sign/zero extension.
- Selects the writeback source and drives the register file write port (`write`/`w_addr`/`data_in`); the register file commits on the falling edge of the same cycle.
- Also exports a forwarding tap for the ID/EX bypass logic and a retired-instruction counter.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_stage_load_extend.sv | 39 +++
 rtl/wb_stage.sv | 119 +++++++++++
 tb/tb_wb_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared codes for the MEM/WB stage: writeback source selects, load types
// and the default link offset.
package wb_pkg;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_LOAD = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  // jal/jalr link skips the delay slot
  localparam logic [31:0] LINK_OFFSET_DEF = 32'd8;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load byte/half extraction and sign/zero extension from a raw aligned word.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_ldtype,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // pick the addressed byte; halfword ignores the low offset bit
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // extend according to load type; unknown types behave as LW
  always_comb begin
    o_data = i_rdata;
    case (i_ldtype)
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'd0, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath. Drives the register file
// write port combinationally during the WB cycle, mirrors it onto the
// forwarding tap, and counts retired instructions.
module wb_stage
  import wb_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter logic [31:0] LINK_OFFSET = LINK_OFFSET_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_wreg,
  input  logic [4:0]       mem_waddr,
  input  logic [1:0]       mem_wsel,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_rdata,
  input  logic [2:0]       mem_ldtype,
  input  logic [31:0]      mem_pc,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             wb_ready,
  output logic             rf_write,
  output logic [4:0]       rf_w_addr,
  output logic [31:0]      rf_data_in,
  output logic             fwd_valid,
  output logic [4:0]       fwd_addr,
  output logic [31:0]      fwd_data,
  output logic             wb_misalign,
  output logic [CNT_W-1:0] retired_cnt
);

  logic             r_valid;
  logic             r_wreg;
  logic [4:0]       r_waddr;
  logic [1:0]       r_wsel;
  logic [31:0]      r_alu;
  logic [31:0]      r_rdata;
  logic [2:0]       r_ldtype;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_retired;

  logic [31:0]      w_load;
  logic [31:0]      w_data;
  logic             w_is_lw;

  // pipeline register: flush beats stall, stall holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_wreg   <= 1'b0;
      r_waddr  <= 5'd0;
      r_wsel   <= 2'd0;
      r_alu    <= 32'd0;
      r_rdata  <= 32'd0;
      r_ldtype <= 3'd0;
      r_pc     <= 32'd0;
    end else if (wb_flush) begin
      r_valid <= 1'b0;
    end else if (!wb_stall) begin
      r_valid  <= mem_valid;
      r_wreg   <= mem_wreg;
      r_waddr  <= mem_waddr;
      r_wsel   <= mem_wsel;
      r_alu    <= mem_alu;
      r_rdata  <= mem_rdata;
      r_ldtype <= mem_ldtype;
      r_pc     <= mem_pc;
    end
  end

  // an instruction retires on the edge it leaves WB, whether or not it wrote
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_retired <= '0;
    else if (r_valid && !wb_stall)
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  load_extend u_load_extend (
    .i_rdata  (r_rdata),
    .i_ldtype (r_ldtype),
    .i_off    (r_alu[1:0]),
    .o_data   (w_load)
  );

  // writeback source select; reserved code falls back to ALU
  always_comb begin
    w_data = r_alu;
    case (r_wsel)
      WSEL_LOAD: w_data = w_load;
      WSEL_LINK: w_data = r_pc + LINK_OFFSET;
      default:   w_data = r_alu;
    endcase
  end

  // write once, on the cycle the instruction leaves; never to $0
  always_comb begin
    rf_write   = r_valid & r_wreg & (r_waddr != 5'd0) & ~wb_stall;
    rf_w_addr  = r_waddr;
    rf_data_in = w_data;
    fwd_valid  = rf_write;
    fwd_addr   = rf_w_addr;
    fwd_data   = rf_data_in;
    wb_ready   = ~wb_stall;
  end

  // misalignment flag is informational; load types outside LB..LHU act as LW
  always_comb begin
    w_is_lw     = !(r_ldtype == LD_LB || r_ldtype == LD_LBU ||
                    r_ldtype == LD_LH || r_ldtype == LD_LHU);
    wb_misalign = r_valid && (r_wsel == WSEL_LOAD) &&
                  ((((r_ldtype == LD_LH) || (r_ldtype == LD_LHU)) && r_alu[0]) ||
                   (w_is_lw && (r_alu[1:0] != 2'd0)));
  end

  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/load/link writeback, $0 suppression,
// stall/flush handling and async reset mid-stall.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [1:0]  mem_wsel;
  logic [31:0] mem_alu;
  logic [31:0] mem_rdata;
  logic [2:0]  mem_ldtype;
  logic [31:0] mem_pc;
  logic        wb_stall;
  logic        wb_flush;
  logic        wb_ready;
  logic        rf_write;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_data_in;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        wb_misalign;
  logic [31:0] retired_cnt;

  int n_cmp;
  int n_err;
  logic [31:0] exp_cnt;

  wb_stage #(.CNT_W(32), .LINK_OFFSET(32'd8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_wreg    (mem_wreg),
    .mem_waddr   (mem_waddr),
    .mem_wsel    (mem_wsel),
    .mem_alu     (mem_alu),
    .mem_rdata   (mem_rdata),
    .mem_ldtype  (mem_ldtype),
    .mem_pc      (mem_pc),
    .wb_stall    (wb_stall),
    .wb_flush    (wb_flush),
    .wb_ready    (wb_ready),
    .rf_write    (rf_write),
    .rf_w_addr   (rf_w_addr),
    .rf_data_in  (rf_data_in),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .wb_misalign (wb_misalign),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for a single edge, then leave a bubble behind it
  task automatic issue(input logic wreg, input logic [4:0] waddr, input logic [1:0] wsel,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [2:0] ldtype, input logic [31:0] pc);
    mem_valid  = 1'b1;
    mem_wreg   = wreg;
    mem_waddr  = waddr;
    mem_wsel   = wsel;
    mem_alu    = alu;
    mem_rdata  = rdata;
    mem_ldtype = ldtype;
    mem_pc     = pc;
    tick();
    mem_valid  = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] ldtype, input logic [1:0] off,
                           input logic [31:0] exp_data, input logic exp_mis);
    issue(1'b1, 5'd7, WSEL_LOAD, {30'd0, off}, 32'h80FF_7F01, ldtype, 32'h0);
    chk({tag, "_we"}, {31'd0, rf_write}, 32'd1);
    chk({tag, "_data"}, rf_data_in, exp_data);
    chk({tag, "_mis"}, {31'd0, wb_misalign}, {31'd0, exp_mis});
    tick();
    exp_cnt++;
    chk({tag, "_cnt"}, retired_cnt, exp_cnt);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_cnt = 0;
    rst = 1'b1; wb_stall = 1'b0; wb_flush = 1'b0;
    mem_valid = 1'b0; mem_wreg = 1'b0; mem_waddr = 5'd0; mem_wsel = 2'd0;
    mem_alu = 32'd0; mem_rdata = 32'd0; mem_ldtype = 3'd0; mem_pc = 32'd0;
    tick(); tick();
    chk("rst_we", {31'd0, rf_write}, 32'd0);
    chk("rst_addr", {27'd0, rf_w_addr}, 32'd0);
    chk("rst_data", rf_data_in, 32'd0);
    chk("rst_fwd", {31'd0, fwd_valid}, 32'd0);
    chk("rst_mis", {31'd0, wb_misalign}, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);
    #2 rst = 1'b0;
    tick();

    // ALU write
    issue(1'b1, 5'd5, WSEL_ALU, 32'h1234_5678, 32'h0, LD_LW, 32'h0);
    chk("alu_we", {31'd0, rf_write}, 32'd1);
    chk("alu_addr", {27'd0, rf_w_addr}, 32'd5);
    chk("alu_data", rf_data_in, 32'h1234_5678);
    chk("alu_fwdv", {31'd0, fwd_valid}, 32'd1);
    chk("alu_fwda", {27'd0, fwd_addr}, 32'd5);
    chk("alu_fwdd", fwd_data, 32'h1234_5678);
    chk("alu_cnt_wb", retired_cnt, 32'd0);
    tick();
    exp_cnt++;
    chk("alu_cnt", retired_cnt, exp_cnt);
    chk("bubble_we", {31'd0, rf_write}, 32'd0);

    // loads on 0x80FF_7F01
    load_case("lb3",  LD_LB,  2'd3, 32'hFFFF_FF80, 1'b0);
    load_case("lbu2", LD_LBU, 2'd2, 32'h0000_00FF, 1'b0);
    load_case("lh2",  LD_LH,  2'd2, 32'hFFFF_80FF, 1'b0);
    load_case("lhu0", LD_LHU, 2'd0, 32'h0000_7F01, 1'b0);
    load_case("lh1",  LD_LH,  2'd1, 32'h0000_7F01, 1'b1);
    load_case("lb1",  LD_LB,  2'd1, 32'h0000_007F, 1'b0);
    load_case("lw2",  LD_LW,  2'd2, 32'h80FF_7F01, 1'b1);
    load_case("lw0",  LD_LW,  2'd0, 32'h80FF_7F01, 1'b0);

    // link with PC wrap
    issue(1'b1, 5'd31, WSEL_LINK, 32'h0, 32'h0, LD_LW, 32'hFFFF_FFFC);
    chk("link_we", {31'd0, rf_write}, 32'd1);
    chk("link_addr", {27'd0, rf_w_addr}, 32'd31);
    chk("link_data", rf_data_in, 32'h0000_0004);
    tick();
    exp_cnt++;

    // reserved wsel behaves as ALU
    issue(1'b1, 5'd3, 2'd3, 32'hCAFE_0001, 32'h0, LD_LW, 32'h100);
    chk("rsv_data", rf_data_in, 32'hCAFE_0001);
    tick();
    exp_cnt++;

    // $0 write suppressed but still retires
    issue(1'b1, 5'd0, WSEL_ALU, 32'hDEAD_BEEF, 32'h0, LD_LW, 32'h0);
    chk("r0_we", {31'd0, rf_write}, 32'd0);
    chk("r0_fwd", {31'd0, fwd_valid}, 32'd0);
    tick();
    exp_cnt++;
    chk("r0_cnt", retired_cnt, exp_cnt);

    // non-writing instruction retires without a write
    issue(1'b0, 5'd4, WSEL_ALU, 32'h1, 32'h0, LD_LW, 32'h0);
    chk("nw_we", {31'd0, rf_write}, 32'd0);
    tick();
    exp_cnt++;
    chk("nw_cnt", retired_cnt, exp_cnt);

    // stall for 3 cycles with a different instruction waiting in MEM
    issue(1'b1, 5'd9, WSEL_ALU, 32'h0000_A5A5, 32'h0, LD_LW, 32'h0);
    wb_stall = 1'b1;
    mem_valid = 1'b1; mem_waddr = 5'd10; mem_alu = 32'h0000_5A5A;
    #1;
    chk("stall_ready", {31'd0, wb_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_we", {31'd0, rf_write}, 32'd0);
      chk("stall_data", rf_data_in, 32'h0000_A5A5);
      chk("stall_addr", {27'd0, rf_w_addr}, 32'd9);
      chk("stall_cnt", retired_cnt, exp_cnt);
      tick();
    end
    mem_valid = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("unstall_ready", {31'd0, wb_ready}, 32'd1);
    chk("unstall_we", {31'd0, rf_write}, 32'd1);
    chk("unstall_addr", {27'd0, rf_w_addr}, 32'd9);
    chk("unstall_data", rf_data_in, 32'h0000_A5A5);
    tick();
    exp_cnt++;
    chk("unstall_cnt", retired_cnt, exp_cnt);
    chk("unstall_once", {31'd0, rf_write}, 32'd0);

    // flush while stalled squashes the held instruction
    issue(1'b1, 5'd11, WSEL_ALU, 32'h0000_1111, 32'h0, LD_LW, 32'h0);
    wb_stall = 1'b1; wb_flush = 1'b1;
    tick();
    wb_stall = 1'b0; wb_flush = 1'b0;
    #1;
    chk("flush_we", {31'd0, rf_write}, 32'd0);
    chk("flush_cnt", retired_cnt, exp_cnt);
    tick();
    chk("flush_cnt2", retired_cnt, exp_cnt);

    // async reset mid-stall discards the held instruction
    issue(1'b1, 5'd12, WSEL_LOAD, 32'h0000_0002, 32'h80FF_7F01, LD_LW, 32'h0);
    wb_stall = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, rf_write}, 32'd0);
    chk("arst_data", rf_data_in, 32'd0);
    chk("arst_mis", {31'd0, wb_misalign}, 32'd0);
    chk("arst_cnt", retired_cnt, 32'd0);
    wb_stall = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("arst_post_we", {31'd0, rf_write}, 32'd0);
    tick();
    chk("arst_post_cnt", retired_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
